gray_stream_checker: RTL and testbench
======================================

Name: gray_stream_checker

Overview:
- Receive-side companion to the team's gray-code counter: accepts a sampled gray-code count stream and decodes it back to binary.
- Verifies that every new sample is a legal successor: one increment, or a hold.
- Tracks lock status and keeps a saturating error count.
- Sits downstream of any gray-coded counter or clock-domain-crossing pointer as a monitor/decoder.

Parameters:
- WIDTH, 4, bit width of gray input and binary output.
- LOCK_LEN, 3, consecutive good increments required to assert locked (1..2^WIDTH-1).
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  sample valid; gray_in is consumed on a rising edge while high.
- gray_in  input  WIDTH  gray-coded count sample.
- clear_errors  input  1  synchronous clear of error_count.
- bin_out  output  WIDTH  decoded binary of the last accepted sample (registered).
- bin_valid  output  1  one-cycle pulse; bin_out was updated this cycle.
- step_error  output  1  one-cycle pulse; the last accepted sample was an illegal successor.
- locked  output  1  high while the stream is in LOCKED state.
- error_count  output  ERR_CNT_W  saturating count of step errors.

Behaviour:
- Reset (reset_n low, asynchronous):
  - bin_out=0, bin_valid=0, step_error=0, locked=0, error_count=0.
  - Internal reference=0, run counter=0, state=EMPTY.
  - Takes effect immediately, mid-stream included.
- Decode (combinational from gray_in): b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i down to 0.
- Output latency:
  - All outputs are registered.
  - A sample accepted at edge N appears on bin_out/bin_valid/step_error/locked after edge N.
- enable low:
  - No state change.
  - bin_valid=0, step_error=0.
  - bin_out, locked and error_count hold.
- Definitions for an accepted sample b, with reference r:
  - Increment: b == (r+1) mod 2^WIDTH, so r=2^WIDTH-1 followed by b=0 is legal.
  - Hold: b == r.
  - Error: anything else.
- State EMPTY (no reference yet):
  - Store r=b, run=0, go to ACQ.
  - No check is performed; step_error=0.
- State ACQ:
  - Increment: run+1. If run+1 == LOCK_LEN, go to LOCKED and set locked=1; otherwise stay.
  - Hold: run unchanged, no error.
  - Error: step_error=1, run=0, stay in ACQ.
- State LOCKED:
  - Increment or hold: stay, no error.
  - Error: step_error=1, run=0, go to ACQ, locked=0 on the same edge.
- Reference update: every accepted sample sets r=b, including error samples (resynchronise to the new value).
- bin_valid=1 for every accepted sample, including the first and error samples.
- error_count:
  - Increments by 1 per step_error.
  - Saturates at 2^ERR_CNT_W-1; never wraps.
- clear_errors:
  - Sets error_count=0.
  - Simultaneous clear_errors and error sample gives error_count=1.
  - Does not affect state, locked or the reference.
- The LOCK_LEN count is consecutive increments; holds neither add to it nor break it.

Test Plan:
- Reset: reset_n low mid-stream (locked=1, error_count=2) -> all outputs 0 immediately, asynchronously. After release, the first sample gray 0011 gives bin_out=2, bin_valid=1, step_error=0, locked=0.
- Lock acquisition (WIDTH=4, LOCK_LEN=3): gray 0000,0001,0011,0010 on consecutive cycles -> bin_out 0,1,2,3 each one cycle later. locked rises after the 4th sample and step_error stays 0 throughout.
- Wrap-around: locked stream at gray 1000 (bin 15), then gray 0000 -> bin_out=0, step_error=0, locked stays 1.
- Skip error: locked at bin 3, feed gray 0111 (bin 5):
  - step_error pulses 1 cycle, error_count=1, locked=0.
  - Then 0101, 0100, 1100 (bins 6, 7, 8) -> locked=1 again after the third.
- Hold and gaps: locked at bin 2, repeat gray 0011 twice, then idle enable=0 for 3 cycles -> no step_error, locked stays 1. bin_valid=0 during the idle cycles and bin_out holds at 2.
- Saturation and clear:
  - Force 260 error samples -> error_count=255, no wrap.
  - clear_errors asserted on the same cycle as an error sample -> error_count=1.
  - clear_errors alone -> error_count=0.

Source files
------------

// File: rtl/gray_stream_checker_if.sv
// gray_stream_checker_if: sample stream in, decoded/status results out
interface gray_stream_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 enable;
    logic [WIDTH-1:0]     gray_in;
    logic                 clear_errors;
    logic [WIDTH-1:0]     bin_out;
    logic                 bin_valid;
    logic                 step_error;
    logic                 locked;
    logic [ERR_CNT_W-1:0] error_count;
    modport master (
        output enable, gray_in, clear_errors,
        input  bin_out, bin_valid, step_error, locked, error_count
    );
    modport slave (
        input  enable, gray_in, clear_errors,
        output bin_out, bin_valid, step_error, locked, error_count
    );
endinterface

// File: rtl/gray_stream_checker.sv
// gray_stream_checker: decodes a gray count stream, checks legal successors, tracks lock and errors
module gray_stream_checker #(
    parameter int WIDTH     = 4,
    parameter int LOCK_LEN  = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    gray_stream_checker_if.slave  s
);
    typedef enum logic [1:0] {EMPTY, ACQ, LOCKED} state_t;
    localparam logic [WIDTH-1:0] LOCK_N = WIDTH'(LOCK_LEN);
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     ref_q, ref_d, run_q, run_d, bin_q, bin_d, dec;
    logic                 valid_q, valid_d, serr_q, serr_d, locked_q, locked_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 is_inc, is_hold;
    always_comb begin
        for (int i = 0; i < WIDTH; i++) dec[i] = ^(s.gray_in >> i);
    end
    assign is_inc  = dec == WIDTH'(ref_q + 1'b1);
    assign is_hold = dec == ref_q;
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        run_d   = run_q;
        bin_d   = bin_q;
        valid_d = 1'b0;
        serr_d  = 1'b0;
        if (s.enable) begin
            bin_d   = dec;
            ref_d   = dec;
            valid_d = 1'b1;
            case (state_q)
                EMPTY: begin
                    run_d   = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    if (is_inc) begin
                        run_d   = WIDTH'(run_q + 1'b1);
                        state_d = (run_d == LOCK_N) ? LOCKED : ACQ;
                    end else if (!is_hold) begin
                        serr_d = 1'b1;
                        run_d  = '0;
                    end
                end
                LOCKED: begin
                    if (!is_inc && !is_hold) begin
                        serr_d  = 1'b1;
                        run_d   = '0;
                        state_d = ACQ;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        locked_d = state_d == LOCKED;
        // clear wins over the old count but still records an error on the same edge
        cnt_d = s.clear_errors ? ERR_CNT_W'(serr_d) :
                (serr_d && cnt_q != '1) ? ERR_CNT_W'(cnt_q + 1'b1) : cnt_q;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            ref_q    <= '0;
            run_q    <= '0;
            bin_q    <= '0;
            valid_q  <= 1'b0;
            serr_q   <= 1'b0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            run_q    <= run_d;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            serr_q   <= serr_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
        end
    end
    assign s.bin_out     = bin_q;
    assign s.bin_valid   = valid_q;
    assign s.step_error  = serr_q;
    assign s.locked      = locked_q;
    assign s.error_count = cnt_q;
endmodule

// File: tb/tb_gray_stream_checker.sv
// tb_gray_stream_checker: directed and random stimulus against a behavioural stream model
module tb_gray_stream_checker;
    localparam int LOCK_LEN = 3;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int m_ref, m_run, m_cnt, m_bin;
    bit m_have, m_lk, m_valid, m_serr;
    gray_stream_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();
    gray_stream_checker #(.WIDTH(4), .LOCK_LEN(LOCK_LEN), .ERR_CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .s(bus)
    );
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int g2b(input int g);
        int r = 0;
        for (int b = 0; b < 16; b++) if (b2g(b) == g) r = b;
        return r;
    endfunction

    task automatic model_reset();
        m_ref = 0; m_run = 0; m_cnt = 0; m_bin = 0;
        m_have = 0; m_lk = 0; m_valid = 0; m_serr = 0;
    endtask

    task automatic model_step(input bit en, input int g, input bit clr);
        int b;
        m_valid = en;
        m_serr  = 0;
        if (en) begin
            b = g2b(g);
            m_bin = b;
            if (!m_have) begin
                m_have = 1;
                m_run = 0;
            end else if (b != (m_ref + 1) % 16 && b != m_ref) begin
                m_serr = 1; m_run = 0; m_lk = 0;
            end else if (b != m_ref && !m_lk) begin
                m_run++;
                if (m_run == LOCK_LEN) m_lk = 1;
            end
            m_ref = b;
        end
        if (clr) m_cnt = m_serr;
        else if (m_serr && m_cnt < 255) m_cnt++;
    endtask

    task automatic cmp_all();
        chk("bin_out", int'(bus.bin_out), m_bin);
        chk("bin_valid", int'(bus.bin_valid), int'(m_valid));
        chk("step_error", int'(bus.step_error), int'(m_serr));
        chk("locked", int'(bus.locked), int'(m_lk));
        chk("error_count", int'(bus.error_count), m_cnt);
    endtask

    task automatic step(input bit en, input int g, input bit clr);
        bus.enable = en;
        bus.gray_in = 4'(g);
        bus.clear_errors = clr;
        @(posedge clock);
        model_step(en, g, clr);
        #1;
        cmp_all();
        @(negedge clock);
    endtask

    task automatic feed_bins(input int from, input int to);
        for (int v = from; v <= to; v++) step(1, b2g(v), 0);
    endtask

    initial begin
        bus.enable = 0;
        bus.gray_in = 0;
        bus.clear_errors = 0;
        model_reset();
        repeat (2) @(negedge clock);
        cmp_all();
        reset_n = 1;
        // lock acquisition
        step(1, 4'b0000, 0);
        step(1, 4'b0001, 0);
        step(1, 4'b0011, 0);
        chk("locked_before_4th", int'(bus.locked), 0);
        step(1, 4'b0010, 0);
        chk("lock_bin3", int'(bus.bin_out), 3);
        chk("lock_rise", int'(bus.locked), 1);
        // skip error then relock
        step(1, 4'b0111, 0);
        chk("skip_err", int'(bus.step_error), 1);
        chk("skip_cnt", int'(bus.error_count), 1);
        chk("skip_unlock", int'(bus.locked), 0);
        step(1, 4'b0101, 0);
        chk("skip_pulse_end", int'(bus.step_error), 0);
        step(1, 4'b0100, 0);
        step(1, 4'b1100, 0);
        chk("relock", int'(bus.locked), 1);
        // wrap-around 15 -> 0
        feed_bins(9, 15);
        step(1, 4'b0000, 0);
        chk("wrap_bin", int'(bus.bin_out), 0);
        chk("wrap_err", int'(bus.step_error), 0);
        chk("wrap_lock", int'(bus.locked), 1);
        // holds and idle gaps
        feed_bins(1, 2);
        step(1, 4'b0011, 0);
        step(1, 4'b0011, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 4'b1111, 0);
            chk("idle_valid", int'(bus.bin_valid), 0);
            chk("idle_bin", int'(bus.bin_out), 2);
            chk("idle_lock", int'(bus.locked), 1);
        end
        // second error, relock, then asynchronous reset mid-stream
        step(1, b2g(5), 0);
        feed_bins(6, 8);
        chk("pre_reset_lock", int'(bus.locked), 1);
        chk("pre_reset_cnt", int'(bus.error_count), 2);
        bus.enable = 0;
        #2;
        reset_n = 0;
        model_reset();
        #1;
        chk("rst_bin", int'(bus.bin_out), 0);
        chk("rst_lock", int'(bus.locked), 0);
        chk("rst_cnt", int'(bus.error_count), 0);
        chk("rst_valid", int'(bus.bin_valid), 0);
        @(negedge clock);
        reset_n = 1;
        step(1, 4'b0011, 0);
        chk("post_rst_bin", int'(bus.bin_out), 2);
        chk("post_rst_valid", int'(bus.bin_valid), 1);
        chk("post_rst_err", int'(bus.step_error), 0);
        chk("post_rst_lock", int'(bus.locked), 0);
        // saturation and clear
        for (int k = 0; k < 260; k++) step(1, (k % 2) ? 0 : b2g(8), 0);
        chk("sat_cnt", int'(bus.error_count), 255);
        step(1, b2g(8), 1);
        chk("clr_with_err", int'(bus.error_count), 1);
        step(0, 0, 1);
        chk("clr_alone", int'(bus.error_count), 0);
        // randomized stream biased toward legal successors
        for (int k = 0; k < 600; k++) begin
            int mode = int'($urandom_range(0, 9));
            int v = (mode < 6) ? (m_ref + 1) % 16 : (mode < 8) ? m_ref : int'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, b2g(v), $urandom_range(0, 24) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
